bram_port_arbiter: RTL

//  Shares one dual-port block RAM (port A: byte-enable write, port B: registered read)

---
 rtl/bram_port_arbiter_pkg.sv | 14 +
 rtl/bram_arb_fairness.sv | 39 +++
 rtl/bram_port_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the BRAM port arbiter: read-owner encodings, read latency,
// and the effective contested-hold limit.
package bram_port_arbiter_pkg;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;
    localparam int   RD_LAT = 1;

    // A limit of 0 would starve M0 entirely; it is treated as 1 so masters alternate.
    function automatic int hold_limit(input int max_hold);
        return (max_hold < 1) ? 1 : max_hold;
    endfunction

endpackage

// File: rtl/bram_arb_fairness.sv
// Fairness tracker: counts consecutive contested M0 grants and selects the winner.
module bram_arb_fairness
    import bram_port_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic m0_req,
    input  logic m1_req,
    output logic sel_m1
);

    localparam int HOLD_LIM = hold_limit(MAX_HOLD);
    localparam int CW       = $clog2(HOLD_LIM + 1);
    localparam logic [CW-1:0] LIM_V = CW'(HOLD_LIM);

    logic [CW-1:0] hold_q, hold_d;

    assign sel_m1 = m1_req & (~m0_req | (hold_q == LIM_V));

    always_comb begin
        hold_d = hold_q;
        if (!m1_req || sel_m1) begin
            hold_d = '0;
        end else if (m0_req && (hold_q != LIM_V)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one dual-port BRAM between a CPU-side master (M0) and a DMA master (M1),
// granting one read or write per cycle and routing registered read data to its owner.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  m0_req,
    input  logic [3:0]            m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic [3:0]            m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb
);

    logic                  sel_m1;
    logic                  any_gnt;
    logic                  rd_gnt;
    logic [3:0]            we_mux;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [31:0]           wdata_mux;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_owner_q, rd_owner_d;

    bram_arb_fairness #(
        .MAX_HOLD(MAX_HOLD)
    ) u_fairness (
        .clk    (HCLK),
        .rst_n  (HRESETn),
        .m0_req (m0_req),
        .m1_req (m1_req),
        .sel_m1 (sel_m1)
    );

    // Grants are masked by the reset pin itself so nothing is accepted while in reset.
    assign m0_gnt  = HRESETn & m0_req & ~sel_m1;
    assign m1_gnt  = HRESETn & sel_m1;
    assign any_gnt = m0_gnt | m1_gnt;

    // With no M1 request the mux rests on M0, so idle cycles present the M0 address.
    assign we_mux    = sel_m1 ? m1_we    : m0_we;
    assign addr_mux  = sel_m1 ? m1_addr  : m0_addr;
    assign wdata_mux = sel_m1 ? m1_wdata : m0_wdata;

    assign ram_wea   = any_gnt ? we_mux : 4'b0000;
    assign ram_addra = addr_mux;
    assign ram_dina  = wdata_mux;
    assign ram_addrb = addr_mux;

    assign rd_gnt     = any_gnt & (we_mux == 4'b0000);
    assign rd_pend_d  = rd_gnt;
    assign rd_owner_d = rd_gnt ? (sel_m1 ? OWN_M1 : OWN_M0) : rd_owner_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_M0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_rvalid = rd_pend_q & (rd_owner_q == OWN_M0);
    assign m1_rvalid = rd_pend_q & (rd_owner_q == OWN_M1);
    assign m0_rdata  = ram_doutb;
    assign m1_rdata  = ram_doutb;

endmodule
